bram_rd_arb: RTL and testbench
==============================

# bram_rd_arb

Read-port arbiter that shares one Bram read port (ren/raddr in, rdv/rdata out, one-cycle read latency) among NREQ requesters in the same clock domain. It selects one requester per cycle using round-robin with a bounded burst, drives the Bram read port, and routes each returned word back to the requester that issued it. It sits between the packet-side consumers (e.g. the TX framer and the stats reader) and the shared buffer memory.

## Interface
- NREQ, 4, number of requesters (2..8; non-power-of-2 allowed)
- DEPTH, 16, Bram depth; AWIDTH = ceil(log2(DEPTH)), minimum 1
- DWIDTH, 32, Bram data width
- BURST_LEN, 4, max consecutive grants to one owner (>=1)

- clk  in  1  single clock for arbiter and attached Bram read port
- arst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester read request; held with addr until gnt
- addr  in  NREQ*AWIDTH  packed addresses, requester k at [k*AWIDTH +: AWIDTH]
- gnt  out  NREQ  one-hot (or zero) grant, combinational, same cycle as bram_ren
- rsp_vld  out  NREQ  one-hot response strobe, one cycle after gnt
- rsp_data  out  DWIDTH  read data, valid where rsp_vld != 0
- bram_ren  out  1  Bram read enable
- bram_raddr  out  AWIDTH  Bram read address
- bram_rdv  in  1  Bram read-valid
- bram_rdata  in  DWIDTH  Bram read data

## Operation
- FSM states: IDLE (no owner), OWN (owner index, burst count cnt).
- Reset: state=IDLE, ptr=0, owner=0, cnt=0, tag=0; gnt=0 and bram_ren=0 while req=0; rsp_vld=0; rsp_data follows bram_rdata (0 from Bram reset).
- Winner search: first k with req[k]=1 scanning from a start index upward, wrapping NREQ-1 -> 0.
- IDLE: start=ptr; if a winner exists, gnt[winner]=1, next OWN with owner=winner, cnt=1; else stay IDLE.
- OWN, req[owner]=1 and cnt<BURST_LEN: gnt[owner]=1, cnt=cnt+1.
- OWN, req[owner]=0 or cnt==BURST_LEN: search from start=(owner+1) mod NREQ (owner itself considered last); winner found -> grant it same cycle, owner=winner, cnt=1 (no bubble); none -> gnt=0, IDLE, ptr=(owner+1) mod NREQ.
- bram_ren = |gnt; bram_raddr = addr slice of granted requester, 0 when no grant.
- tag register loads gnt every cycle; rsp_vld = tag & {NREQ{bram_rdv}}; rsp_data = bram_rdata.
- cnt width ceil(log2(BURST_LEN+1)); never exceeds BURST_LEN.
- Requester dropping req without gnt is legal; no grant issued for it.

## Timing
- Grant latency: 0 cycles (gnt combinational from req and registered state).
- Read latency: rsp_vld/rsp_data exactly 1 cycle after gnt; back-to-back grants give back-to-back responses, one per cycle.
- Throughput: 1 read per cycle whenever any req is high.
- Ownership switch costs no idle cycle.
- Reset mid-operation: state, tag, ptr cleared asynchronously; in-flight response discarded (rsp_vld=0 on first cycle after release even if a read was issued before reset).
- BURST_LEN=1 degenerates to pure round-robin.

## Configuration
- BRAM_RD_ARB_RR_EN defined: round-robin with burst as above.
- Not defined: fixed priority; every cycle lowest-index requesting k is granted; FSM, ptr and cnt removed; BURST_LEN ignored; tag/response path unchanged.

## Test plan
- Reset then single requester: req=4'b0010, addr[1]=5 -> gnt=4'b0010 same cycle, bram_raddr=5; next cycle rsp_vld=4'b0010, rsp_data=mem[5].
- All four requesting continuously, BURST_LEN=4 -> grants 0,0,0,0,1,1,1,1,2,... with no gap; responses track grants with 1-cycle lag.
- Owner 2 drops req after 2 grants while req[0] high -> next cycle gnt=4'b0001, cnt=1; later after idle, ptr=1 so req[1] and req[0] together grant 1 first.
- Wrap: owner 3 hits BURST_LEN, only req[0] high -> gnt=4'b0001.
- arst_n low for one cycle right after a grant -> rsp_vld stays 0, gnt=0 until req re-sampled, next grant starts from requester 0.
- Without BRAM_RD_ARB_RR_EN: req=4'b1110 continuously -> gnt=4'b0010 every cycle.

Source files
------------

// File: rtl/bram_rd_arb.sv
// rtl/bram_rd_arb.sv - shared Bram read-port arbiter with per-requester response routing
// Optional BRAM_RD_ARB_RR_EN: round-robin with bounded burst; otherwise fixed lowest-index priority.
module bram_rd_arb #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 16,
  parameter int DWIDTH    = 32,
  parameter int BURST_LEN = 4,
  localparam int AWIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*AWIDTH-1:0]   addr,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_vld,
  output logic [DWIDTH-1:0]        rsp_data,
  output logic                     bram_ren,
  output logic [AWIDTH-1:0]        bram_raddr,
  input  logic                     bram_rdv,
  input  logic [DWIDTH-1:0]        bram_rdata
);

  localparam int IW = $clog2(NREQ);

  // Scan req upward from start, wrapping at NREQ-1; MSB of result flags a winner.
  function automatic logic [IW:0] find_winner(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   start);
    logic [IW:0] res;
    logic [IW:0] s;
    res = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = {1'b0, start} + (IW+1)'(i);
      if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
      if (!res[IW] && r[s[IW-1:0]]) res = {1'b1, s[IW-1:0]};
    end
    return res;
  endfunction

  logic          gvalid;
  logic [IW-1:0] gidx;
  logic [NREQ-1:0] tag_q;

`ifdef BRAM_RD_ARB_RR_EN
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] owner_nx;
  logic [IW-1:0] start;
  logic [IW:0]   win;

  // Arbitration FSM state: owner keeps the port for up to BURST_LEN grants.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and grant selection; ownership hand-off happens in the same cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gvalid   = 1'b0;
    gidx     = '0;
    owner_nx = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
    start    = (state_q == IDLE) ? ptr_q : owner_nx;
    win      = find_winner(req, start);
    case (state_q)
      IDLE: begin
        if (win[IW]) begin
          gvalid  = 1'b1;
          gidx    = win[IW-1:0];
          state_d = OWN;
          owner_d = win[IW-1:0];
          cnt_d   = CW'(1);
        end
      end
      OWN: begin
        if (req[owner_q] && (cnt_q < CW'(BURST_LEN))) begin
          gvalid = 1'b1;
          gidx   = owner_q;
          cnt_d  = cnt_q + CW'(1);
        end else if (win[IW]) begin
          gvalid  = 1'b1;
          gidx    = win[IW-1:0];
          owner_d = win[IW-1:0];
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
          ptr_d   = owner_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  logic [IW:0] win;

  // Fixed priority: lowest-index requester wins every cycle.
  always_comb begin
    win    = find_winner(req, '0);
    gvalid = win[IW];
    gidx   = win[IW-1:0];
  end
`endif

  // One-hot grant and address mux toward the Bram read port.
  always_comb begin
    gnt        = '0;
    bram_raddr = '0;
    if (gvalid) begin
      gnt        = NREQ'(1) << gidx;
      bram_raddr = addr[gidx*AWIDTH +: AWIDTH];
    end
  end

  assign bram_ren = gvalid;

  // Remember who was granted so the returning word is steered to them.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) tag_q <= '0;
    else         tag_q <= gnt;
  end

  assign rsp_vld  = tag_q & {NREQ{bram_rdv}};
  assign rsp_data = bram_rdata;

endmodule

// File: tb/tb_bram_rd_arb.sv
// tb/tb_bram_rd_arb.sv - directed self-checking bench for bram_rd_arb
module tb_bram_rd_arb;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [3:0]  req;
  logic [15:0] addr;
  logic [3:0]  gnt;
  logic [3:0]  rsp_vld;
  logic [31:0] rsp_data;
  logic        bram_ren;
  logic [3:0]  bram_raddr;
  logic        bram_rdv = 1'b0;
  logic [31:0] bram_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  bram_rd_arb #(.NREQ(4), .DEPTH(16), .DWIDTH(32), .BURST_LEN(4)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .req        (req),
    .addr       (addr),
    .gnt        (gnt),
    .rsp_vld    (rsp_vld),
    .rsp_data   (rsp_data),
    .bram_ren   (bram_ren),
    .bram_raddr (bram_raddr),
    .bram_rdv   (bram_rdv),
    .bram_rdata (bram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [3:0] a);
    return 32'hA5A5_0000 + {28'd0, a} * 32'h111;
  endfunction

  // Bram with one-cycle read latency; not reset, so stale rdv survives arbiter reset.
  always @(posedge clk) begin
    bram_rdv <= bram_ren;
    if (bram_ren) bram_rdata <= memval(bram_raddr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive req, check same-cycle grant, then check response after the edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] eg, input string tag);
    logic [3:0] ea;
    ea = '0;
    for (int k = 0; k < 4; k++) if (eg[k]) ea = addr[k*4 +: 4];
    req = r;
    #1;
    check({tag, ".gnt"}, {28'd0, gnt}, {28'd0, eg});
    check({tag, ".ren"}, {31'd0, bram_ren}, {31'd0, |eg});
    check({tag, ".raddr"}, {28'd0, bram_raddr}, {28'd0, ea});
    @(posedge clk); #1;
    check({tag, ".rsp_vld"}, {28'd0, rsp_vld}, {28'd0, eg});
    if (eg != 4'd0) check({tag, ".rsp_data"}, rsp_data, memval(ea));
  endtask

  task automatic do_reset();
    req = '0;
    arst_n = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n = 1'b0;
    req    = '0;
    addr   = {4'd15, 4'd9, 4'd5, 4'd3};
    @(posedge clk); @(posedge clk); #1;
    arst_n = 1'b1;
    #1;
    check("rst.gnt", {28'd0, gnt}, 32'd0);
    check("rst.ren", {31'd0, bram_ren}, 32'd0);
    check("rst.raddr", {28'd0, bram_raddr}, 32'd0);
    check("rst.rsp_vld", {28'd0, rsp_vld}, 32'd0);
    check("rst.rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;

    cycle(4'b0010, 4'b0010, "single");
    cycle(4'b0000, 4'b0000, "single_idle");

`ifdef BRAM_RD_ARB_RR_EN
    do_reset();
    for (int i = 0; i < 17; i++) begin
      logic [3:0] e;
      e = 4'b0001 << ((i / 4) % 4);
      cycle(4'b1111, e, $sformatf("burst%0d", i));
    end

    do_reset();
    cycle(4'b0100, 4'b0100, "drop.own2a");
    cycle(4'b0100, 4'b0100, "drop.own2b");
    cycle(4'b0001, 4'b0001, "drop.to0");
    cycle(4'b0000, 4'b0000, "drop.idle");
    cycle(4'b0011, 4'b0010, "drop.ptr1");

    do_reset();
    for (int i = 0; i < 4; i++) cycle(4'b1000, 4'b1000, $sformatf("wrap.own3_%0d", i));
    cycle(4'b1001, 4'b0001, "wrap.to0");
`else
    cycle(4'b1110, 4'b0010, "fp.a");
    cycle(4'b1110, 4'b0010, "fp.b");
    cycle(4'b1110, 4'b0010, "fp.c");
    cycle(4'b1100, 4'b0100, "fp.d");
    cycle(4'b1000, 4'b1000, "fp.e");
    cycle(4'b1111, 4'b0001, "fp.f");
`endif

    do_reset();
    req = 4'b0001;
    #1;
    check("mid.gnt", {28'd0, gnt}, 32'h1);
    @(posedge clk); #1;
    check("mid.rsp_pre", {28'd0, rsp_vld}, 32'h1);
    arst_n = 1'b0;
    #1;
    check("mid.rsp_async", {28'd0, rsp_vld}, 32'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    req = '0;
    #1;
    check("mid.rsp_after", {28'd0, rsp_vld}, 32'd0);
    check("mid.gnt_after", {28'd0, gnt}, 32'd0);
    @(posedge clk); #1;
    cycle(4'b1010, 4'b0010, "mid.restart");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
